// File: rtl/seq_check_sft.sv
// Serial bit-sequence detector built on a shift register, no FSM.
// Optional saturating match counter on match_cnt when SEQ_MATCH_CNT_EN is defined.
module seq_check_sft #(
    parameter int          SEQ_LEN = 8,
    parameter logic [31:0] PATTERN = 32'h0000_00B7,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
`ifdef SEQ_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             success_flag
);

    localparam int FW = $clog2(SEQ_LEN + 1);

    // Only the low SEQ_LEN bits of PATTERN take part in the compare.
    localparam logic [SEQ_LEN-1:0] PAT = PATTERN[SEQ_LEN-1:0];

    localparam logic [FW-1:0] FILL_MAX  = FW'(SEQ_LEN);
    localparam logic [FW-1:0] FILL_LAST = FW'(SEQ_LEN - 1);

    // The oldest bit of the window falls out on the next shift, so
    // only SEQ_LEN-1 bits of history need storing; din completes it.
    logic [SEQ_LEN-2:0] r_hist;
    logic [FW-1:0]      r_fill;
    logic               r_flag;

    logic [SEQ_LEN-1:0] w_win;
    logic               w_full;
    logic               w_match;

    assign w_win = {r_hist, din};

    // (fill + 1) >= SEQ_LEN, written without the carry bit.
    assign w_full = (r_fill >= FILL_LAST);

    // The fill qualifier keeps reset zeros from matching zero-led patterns.
    assign w_match = w_full && (w_win == PAT);

    // Shift history and fill count; fill saturates at SEQ_LEN.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_hist <= w_win[SEQ_LEN-2:0];
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Registered one-cycle match pulse per matching window.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= w_match;
        end
    end

    assign success_flag = r_flag;

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Count matches since reset, holding at all ones.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_check_sft.sv
// Directed and soak bench for seq_check_sft.
// Second instance exercises an all-zero 4-bit pattern.
module tb_seq_check_sft;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_z;
    logic       flag;
    logic       flag_z;
    logic [3:0] cnt;
    logic [3:0] cnt_z;

    int n_vec;
    int n_err;

    seq_check_sft #(
        .SEQ_LEN (8),
        .PATTERN (32'h0000_00B7),
        .CNT_W   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
`ifdef SEQ_MATCH_CNT_EN
        .match_cnt    (cnt),
`endif
        .success_flag (flag)
    );

    seq_check_sft #(
        .SEQ_LEN (4),
        .PATTERN (32'h0000_0000),
        .CNT_W   (4)
    ) dut_z (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din_z),
`ifdef SEQ_MATCH_CNT_EN
        .match_cnt    (cnt_z),
`endif
        .success_flag (flag_z)
    );

`ifndef SEQ_MATCH_CNT_EN
    assign cnt   = 4'd0;
    assign cnt_z = 4'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge, reset released.
    task automatic do_reset();
        rst_n = 1'b1;
        din   = 1'b0;
        @(negedge clk);
        check("rst_flag", {31'd0, flag}, 32'd0);
        check("rst_flag_z", {31'd0, flag_z}, 32'd0);
`ifdef SEQ_MATCH_CNT_EN
        check("rst_cnt", {28'd0, cnt}, 32'd0);
`endif
        rst_n = 1'b0;
    endtask

    // Drive a bit at the falling edge, check flag one cycle later.
    task automatic push(input string tag, input logic b, input logic e);
        din = b;
        @(negedge clk);
        check(tag, {31'd0, flag}, {31'd0, e});
    endtask

    // Apply n bits (MSB first) with expected flags (MSB first).
    task automatic run_vec(input string tag, input int n,
                           input logic [31:0] bits, input logic [31:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            push(tag, bits[i], exp[i]);
        end
    endtask

    logic [7:0] m_win;
    logic [7:0] m_hist;
    int         m_fill;
    int         m_cnt;
    logic       m_flag;
    logic       b;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        din   = 1'b0;
        din_z = 1'b0;
        @(negedge clk);

        // 1: single match, flag for exactly one cycle
        do_reset();
        run_vec("t1_match", 8, 32'b1011_0111, 32'b0000_0001);
        push("t1_after", 1'b0, 1'b0);
`ifdef SEQ_MATCH_CNT_EN
        check("t1_cnt", {28'd0, cnt}, 32'd1);
`endif

        // 2: overlapping matches at bits 8 and 15
        do_reset();
        run_vec("t2_overlap", 15, 32'b101_1011_1011_0111,
                32'b000_0000_1000_0001);
`ifdef SEQ_MATCH_CNT_EN
        check("t2_cnt", {28'd0, cnt}, 32'd2);
`endif

        // 3: near miss; after 1,1,1 bits 4..11 read 10110111
        do_reset();
        run_vec("t3_near", 8, 32'b1011_0110, 32'b0000_0000);
        run_vec("t3_tail", 3, 32'b111, 32'b001);

        // 4: reset mid-sequence discards history
        do_reset();
        run_vec("t4_part", 7, 32'b101_1011, 32'b000_0000);
        check("t4_z_pre", {31'd0, flag_z}, 32'd1);
        #2 rst_n = 1'b1;
        #1 check("t4_z_clr", {31'd0, flag_z}, 32'd0);
        check("t4_flag_rst", {31'd0, flag}, 32'd0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        push("t4_one", 1'b1, 1'b0);
        run_vec("t4_full", 8, 32'b1011_0111, 32'b0000_0001);

        // 5: all-zero 4-bit pattern needs four fresh bits
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            din = 1'b1;
            @(negedge clk);
            check("t5_zero", {31'd0, flag_z}, {31'd0, (i >= 4)});
        end

        // 6: random soak against a shift model
        do_reset();
        m_hist = 8'd0;
        m_fill = 0;
        m_cnt  = 0;
        for (int i = 0; i < 10000; i++) begin
            b      = 1'($urandom_range(0, 1));
            m_win  = {m_hist[6:0], b};
            m_flag = (m_win == 8'hB7) && (m_fill + 1 >= 8);
            if (m_flag && m_cnt < 15) m_cnt++;
            m_hist = m_win;
            if (m_fill < 8) m_fill++;
            din = b;
            @(negedge clk);
            check("t6_flag", {31'd0, flag}, {31'd0, m_flag});
`ifdef SEQ_MATCH_CNT_EN
            check("t6_cnt", {28'd0, cnt}, m_cnt);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
